// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: mult in 1 cycle (FAST_MULT=1) or 32 iterations, div always 32 iterations, done in C33.
// No input handshake: while an iterative op is in flight, HI/LO and mult/div instructions raise stall and are held upstream.
module mult_div_unit #(
    parameter int FAST_MULT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam logic       FAST   = (FAST_MULT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] work_hi;
    logic [31:0] work_lo;
    logic        neg_res;
    logic        neg_rem;
    logic        done_q;

    logic        is_md;
    logic        is_hilo;
    logic        start;
    logic        op_signed;
    logic        last;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic        neg_res_in;
    logic        neg_rem_in;
    logic [63:0] fast_mag;
    logic [63:0] fast_prod;
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_nxt;
    logic [31:0] mul_lo_nxt;
    logic [63:0] mul_prod;
    logic [63:0] mul_final;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ok;
    logic [31:0] div_hi_nxt;
    logic [31:0] div_lo_nxt;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

    // funct 0x18..0x1B: bit1 selects div, bit0 selects unsigned
    assign is_md      = (funct[5:2] == 4'b0110);
    assign is_hilo    = (funct[5:2] == 4'b0100);
    assign start      = (state == IDLE) && op_valid && is_md;
    assign op_signed  = ~funct[0];
    assign last       = (cnt == 5'd31);

    assign mag_a_in   = (op_signed && a[31]) ? -a : a;
    assign mag_b_in   = (op_signed && b[31]) ? -b : b;
    assign neg_res_in = op_signed && (a[31] ^ b[31]);
    assign neg_rem_in = op_signed && a[31];

    assign fast_mag   = {32'd0, mag_a_in} * {32'd0, mag_b_in};
    assign fast_prod  = neg_res_in ? -fast_mag : fast_mag;

    // Shift-add: work_lo holds remaining multiplier bits, product shifts in from the top
    assign mul_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_hi_nxt = mul_sum[32:1];
    assign mul_lo_nxt = {mul_sum[0], work_lo[31:1]};
    assign mul_prod   = {mul_hi_nxt, mul_lo_nxt};
    assign mul_final  = neg_res ? -mul_prod : mul_prod;

    // Restoring division; a zero divisor naturally yields q = all ones, r = dividend
    assign div_shift  = {work_hi, work_lo[31]};
    assign div_ok     = (div_shift >= {1'b0, mag_b});
    assign div_diff   = div_shift[31:0] - mag_b;
    assign div_hi_nxt = div_ok ? div_diff : div_shift[31:0];
    assign div_lo_nxt = {work_lo[30:0], div_ok};
    assign quo_final  = neg_res ? -div_lo_nxt : div_lo_nxt;
    assign rem_final  = neg_rem ? -div_hi_nxt : div_hi_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (funct[1]) begin
                        state_nxt = DIV;
                    end else if (!FAST) begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            cnt     <= 5'd0;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            work_hi <= 32'd0;
            work_lo <= 32'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a   <= mag_a_in;
                        mag_b   <= mag_b_in;
                        neg_res <= neg_res_in;
                        neg_rem <= neg_rem_in;
                        cnt     <= 5'd0;
                        work_hi <= 32'd0;
                        work_lo <= funct[1] ? mag_a_in : mag_b_in;
                        if (!funct[1] && FAST) begin
                            hi     <= fast_prod[63:32];
                            lo     <= fast_prod[31:0];
                            done_q <= 1'b1;
                        end
                    end else if (op_valid && funct == F_MTHI) begin
                        hi <= a;
                    end else if (op_valid && funct == F_MTLO) begin
                        lo <= a;
                    end
                end
                MUL: begin
                    work_hi <= mul_hi_nxt;
                    work_lo <= mul_lo_nxt;
                    cnt     <= cnt + 5'd1;
                    if (last) begin
                        hi     <= mul_final[63:32];
                        lo     <= mul_final[31:0];
                        done_q <= 1'b1;
                    end
                end
                DIV: begin
                    work_hi <= div_hi_nxt;
                    work_lo <= div_lo_nxt;
                    cnt     <= cnt + 5'd1;
                    if (last) begin
                        hi     <= rem_final;
                        lo     <= quo_final;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy && op_valid && (is_md || is_hilo);
    assign done  = done_q;

    always_comb begin
        result = 32'd0;
        if (funct == F_MFHI) begin
            result = hi;
        end else if (funct == F_MFLO) begin
            result = lo;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a slow (FAST_MULT=0) and a fast (FAST_MULT=1) instance share one input stream.
module tb_mult_div_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;

    logic        s_stall, s_busy, s_done;
    logic [31:0] s_result, s_hi, s_lo;
    logic        f_stall, f_busy, f_done;
    logic [31:0] f_result, f_hi, f_lo;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit #(.FAST_MULT(0)) dut_s (
        .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct), .a(a), .b(b),
        .stall(s_stall), .busy(s_busy), .done(s_done), .result(s_result), .hi(s_hi), .lo(s_lo)
    );

    mult_div_unit #(.FAST_MULT(1)) dut_f (
        .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct), .a(a), .b(b),
        .stall(f_stall), .busy(f_busy), .done(f_done), .result(f_result), .hi(f_hi), .lo(f_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        op_valid = v;
        funct    = f;
        a        = av;
        b        = bv;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        tick();
        tick();
        n_cmp++;
        if ({s_hi, s_lo, s_busy, s_stall, s_done} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_slow: got hi=%h lo=%h busy=%b stall=%b done=%b, want all zero", s_hi, s_lo, s_busy, s_stall, s_done);
        end
        n_cmp++;
        if ({f_hi, f_lo, f_busy, f_stall, f_done} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_fast: got hi=%h lo=%h busy=%b stall=%b done=%b, want all zero", f_hi, f_lo, f_busy, f_stall, f_done);
        end
        drive(1'b1, F_MTHI, 32'hDEAD_BEEF, 32'h0);
        tick();
        n_cmp++;
        if (s_hi !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_over_mthi: got hi=%h want 00000000", s_hi);
        end
        drive(1'b1, F_DIV, 32'd100, 32'd7);
        tick();
        n_cmp++;
        if (s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_over_start: got busy=%b want 0", s_busy);
        end
        reset = 1'b0;
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_hilo_moves();
        drive(1'b1, F_MTHI, 32'h0000_1234, 32'h0);
        tick();
        n_cmp++;
        if ({s_hi, s_lo} !== 64'h0000_1234_0000_0000) begin
            n_bad++;
            $display("FAIL mthi: got %h_%h want 00001234_00000000", s_hi, s_lo);
        end
        drive(1'b1, F_MTLO, 32'h0000_5678, 32'h0);
        tick();
        n_cmp++;
        if ({s_hi, s_lo} !== 64'h0000_1234_0000_5678) begin
            n_bad++;
            $display("FAIL mtlo: got %h_%h want 00001234_00005678", s_hi, s_lo);
        end
        drive(1'b1, F_ADDU, 32'hFFFF_FFFF, 32'h1);
        tick();
        drive(1'b0, F_MTHI, 32'hAAAA_AAAA, 32'h1);
        tick();
        n_cmp++;
        if ({s_hi, s_lo} !== 64'h0000_1234_0000_5678) begin
            n_bad++;
            $display("FAIL no_side_effect: got %h_%h want 00001234_00005678", s_hi, s_lo);
        end
        drive(1'b1, F_MFHI, 32'h0, 32'h0);
        n_cmp++;
        if (s_result !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL mfhi_result: got %h want 00001234", s_result);
        end
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        n_cmp++;
        if (s_result !== 32'h0000_5678) begin
            n_bad++;
            $display("FAIL mflo_result: got %h want 00005678", s_result);
        end
        drive(1'b1, F_ADDU, 32'h0, 32'h0);
        n_cmp++;
        if (s_result !== 32'h0) begin
            n_bad++;
            $display("FAIL other_result: got %h want 00000000", s_result);
        end
        tick();
        drive(1'b0, 6'h0, 32'h0, 32'h0);
    endtask

    task automatic test_multu_slow();
        drive(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        n_cmp++;
        if ({f_hi, f_lo, f_done, f_busy} !== {64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL multu_fast_c1: got %h_%h done=%b busy=%b want fffffffe_00000001 done=1 busy=0", f_hi, f_lo, f_done, f_busy);
        end
        for (int k = 1; k <= 32; k++) begin
            n_cmp++;
            if ({s_busy, s_done, s_hi, s_lo} !== {1'b1, 1'b0, 64'h0000_1234_0000_5678}) begin
                n_bad++;
                $display("FAIL multu_slow_c%0d: got busy=%b done=%b hilo=%h_%h want busy=1 done=0 hilo=00001234_00005678", k, s_busy, s_done, s_hi, s_lo);
            end
            tick();
        end
        n_cmp++;
        if ({s_busy, s_done, s_hi, s_lo} !== {1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001}) begin
            n_bad++;
            $display("FAIL multu_slow_c33: got busy=%b done=%b hilo=%h_%h want busy=0 done=1 hilo=fffffffe_00000001", s_busy, s_done, s_hi, s_lo);
        end
        tick();
        n_cmp++;
        if (s_done !== 1'b0) begin
            n_bad++;
            $display("FAIL multu_slow_c34_done: got %b want 0", s_done);
        end
    endtask

    task automatic test_mult_fast();
        drive(1'b1, F_MULT, 32'hFFFF_FFFD, 32'd5);
        tick();
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        n_cmp++;
        if ({f_hi, f_lo, f_done, f_busy} !== {64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mult_fast_c1: got %h_%h done=%b busy=%b want ffffffff_fffffff1 done=1 busy=0", f_hi, f_lo, f_done, f_busy);
        end
        for (int k = 1; k <= 32; k++) begin
            tick();
        end
        n_cmp++;
        if ({s_hi, s_lo, s_done, f_done, f_busy} !== {64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mult_slow_c33: got %h_%h sdone=%b fdone=%b fbusy=%b want ffffffff_fffffff1 1 0 0", s_hi, s_lo, s_done, f_done, f_busy);
        end
    endtask

    logic [5:0]  dv_f  [0:6] = '{F_DIV, F_DIVU, F_DIV, F_DIV, F_DIV, F_DIVU, F_DIV};
    logic [31:0] dv_a  [0:6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd100, 32'd7};
    logic [31:0] dv_b  [0:6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFE};
    logic [63:0] dv_hl [0:6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0007_FFFF_FFFF, 64'h0000_0000_8000_0000,
                                 64'h0000_0007_FFFF_FFFF, 64'hFFFF_FFF9_0000_0001, 64'h0000_0002_0000_000E,
                                 64'h0000_0001_FFFF_FFFD};

    task automatic test_div();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, dv_f[i], dv_a[i], dv_b[i]);
            tick();
            drive(1'b0, 6'h0, 32'h0, 32'h0);
            for (int k = 1; k <= 32; k++) begin
                tick();
            end
            n_cmp++;
            if ({s_hi, s_lo, s_done, f_hi, f_lo, f_done} !== {dv_hl[i], 1'b1, dv_hl[i], 1'b1}) begin
                n_bad++;
                $display("FAIL div_vec%0d: got slow %h_%h done=%b fast %h_%h done=%b want %h done=1",
                         i, s_hi, s_lo, s_done, f_hi, f_lo, f_done, dv_hl[i]);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, F_DIV, 32'd100, 32'd7);
        tick();
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        for (int k = 1; k <= 32; k++) begin
            n_cmp++;
            if (s_stall !== 1'b1) begin
                n_bad++;
                $display("FAIL mflo_stall_c%0d: got %b want 1", k, s_stall);
            end
            tick();
        end
        n_cmp++;
        if ({s_stall, s_result} !== {1'b0, 32'h0000_000E}) begin
            n_bad++;
            $display("FAIL mflo_c33: got stall=%b result=%h want stall=0 result=0000000e", s_stall, s_result);
        end
        tick();
        drive(1'b1, F_DIV, 32'd100, 32'd7);
        tick();
        drive(1'b1, F_ADDU, 32'd1, 32'd2);
        n_cmp++;
        if ({s_stall, s_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL addu_no_stall: got stall=%b busy=%b want stall=0 busy=1", s_stall, s_busy);
        end
        tick();
        drive(1'b1, F_MTHI, 32'h0000_AAAA, 32'h0);
        for (int k = 2; k <= 32; k++) begin
            tick();
        end
        n_cmp++;
        if ({s_stall, s_hi} !== {1'b0, 32'h0000_0002}) begin
            n_bad++;
            $display("FAIL held_mthi_c33: got stall=%b hi=%h want stall=0 hi=00000002", s_stall, s_hi);
        end
        tick();
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        n_cmp++;
        if ({s_hi, s_lo} !== 64'h0000_AAAA_0000_000E) begin
            n_bad++;
            $display("FAIL held_mthi_c34: got %h_%h want 0000aaaa_0000000e", s_hi, s_lo);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, F_MTHI, 32'h0000_1234, 32'h0);
        tick();
        drive(1'b1, F_DIV, 32'd100, 32'd7);
        tick();
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        for (int k = 1; k < 10; k++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({s_hi, s_lo, s_busy, s_done} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b want all zero", s_hi, s_lo, s_busy, s_done);
        end
        drive(1'b1, F_MTLO, 32'h0000_0055, 32'h0);
        tick();
        drive(1'b0, 6'h0, 32'h0, 32'h0);
        n_cmp++;
        if ({s_hi, s_lo} !== 64'h0000_0000_0000_0055) begin
            n_bad++;
            $display("FAIL mtlo_after_reset: got %h_%h want 00000000_00000055", s_hi, s_lo);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
        end
        n_cmp++;
        if ({s_hi, s_lo, s_busy, s_done} !== {64'h0000_0000_0000_0055, 2'b00}) begin
            n_bad++;
            $display("FAIL abandoned_div: got %h_%h busy=%b done=%b want 00000000_00000055 busy=0 done=0", s_hi, s_lo, s_busy, s_done);
        end
    endtask

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        funct    = 6'h0;
        a        = 32'h0;
        b        = 32'h0;
        test_reset();
        test_hilo_moves();
        test_multu_slow();
        test_mult_fast();
        test_div();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter FAST_MULT, default 1; 1 = single-cycle multiply, 0 = 32-iteration shift-add multiply.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  EX stage holds a SPECIAL-opcode instruction this cycle.
REQ-005 SHALL have port funct  input  6  MIPS funct field, decoded as follows:
- 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo
- 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
REQ-006 SHALL have port a  input  32  rs operand.
REQ-007 SHALL have port b  input  32  rt operand.
REQ-008 SHALL have port stall  output  1  freeze request to the hazard unit for IF/ID/EX.
REQ-009 SHALL have port busy  output  1  an iterative operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse after HI/LO are written by mult/div.
REQ-011 SHALL have port result  output  32  mfhi/mflo read data, combinational: hi for 0x10, lo for 0x12, else 0.
REQ-012 SHALL have ports hi and lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV; busy = (state != IDLE).
REQ-014 SHALL define start cycle C0 as IDLE & op_valid & funct in {0x18..0x1B}.
REQ-015 On the edge ending C0, SHALL latch |a| and |b| (magnitudes only for signed ops), the result sign, the remainder sign, and op type; SHALL clear the iteration counter.
REQ-016 On the edge ending C0, SHALL enter DIV for div/divu, and MUL for mult/multu when FAST_MULT=0.
REQ-017 When FAST_MULT=1, mult/multu SHALL write the full 64-bit product {hi,lo} on the edge ending C0, stay in IDLE, and pulse done in C1.
REQ-018 SHALL run one iteration per cycle in C1..C32:
- MUL: radix-2 shift-add.
- DIV: radix-2 restoring division.
REQ-019 On the edge ending C32, SHALL apply sign fixups, write hi/lo, and return to IDLE; done SHALL be 1 in C33 only.
REQ-020 SHALL set signs as follows:
- Signed product: negated when sign(a) != sign(b).
- Quotient (lo): negated when sign(a) != sign(b).
- Remainder (hi): takes the sign of a.
REQ-021 On divide by zero:
- divu SHALL give lo = 0xFFFFFFFF, hi = a.
- div SHALL give hi = a; lo = 0x00000001 if a < 0, else 0xFFFFFFFF.
REQ-022 div 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0; no trap.
REQ-023 SHALL drive stall = busy & op_valid & funct in {0x10..0x13, 0x18..0x1B}; other instructions SHALL proceed while busy.
REQ-024 While stall = 1, upstream SHALL hold op_valid/funct/a/b stable; the unit SHALL NOT accept the held op until stall = 0.
REQ-025 mthi/mtlo in IDLE (not stalled) SHALL write hi/lo = a on the next edge; the other register SHALL be unchanged.
REQ-026 mfhi/mflo SHALL have no side effect; result SHALL reflect hi/lo written on any prior edge.
REQ-027 op_valid with any funct outside REQ-005, or op_valid = 0, SHALL leave all state unchanged.
REQ-028 hi/lo SHALL NOT change during C1..C32 except at the final edge.

Reset
REQ-029 While reset = 1 at a rising edge, the next cycle SHALL have:
- state = IDLE, counter = 0
- hi = lo = 0x00000000
- busy = stall = done = 0
REQ-030 Reset mid-operation SHALL abandon the operation with no HI/LO write; the op in C0 of the first post-reset cycle SHALL be accepted normally.
REQ-031 Reset SHALL take priority over every simultaneous start, mthi/mtlo, or completion.

Verification
REQ-032 FAST_MULT=0, multu a = b = 0xFFFFFFFF -> busy C1..C32, hi = 0xFFFFFFFE, lo = 0x00000001 from C33, done = 1 only in C33.
REQ-033 FAST_MULT=1, mult a = 0xFFFFFFFD (-3), b = 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1 in C1, busy never 1, done in C1.
REQ-034 Division results:
- div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu 7 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000007.
- div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-035 div 100 / 7 then mflo held in C1 -> stall = 1 C1..C32, stall = 0 in C33 with result = 0x0000000E. An addu issued in C1 of a separate run -> stall = 0.
REQ-036 Reset asserted in C10 of a div after mthi 0x1234 -> next cycle hi = lo = 0, busy = 0; then mtlo 0x55 -> lo = 0x55, hi = 0.
